// File: rtl/t_ff_counter_pkg.sv
// Shared types and helpers for the T flip-flop up/down counter.
// t_vec gives the per-bit toggle vector for a +1 / -1 step of the count.
package t_ff_counter_pkg;

    localparam int T_FF_WIDTH = 4;

    typedef logic [T_FF_WIDTH-1:0] cnt_t;

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    function automatic cnt_t t_vec(input cnt_t q, input logic up);
        cnt_t t;
        t[0] = 1'b1;
        for (int i = 1; i < T_FF_WIDTH; i++) begin
            t[i] = t[i-1] & (up ? q[i-1] : ~q[i-1]);
        end
        return t;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: q toggles on a rising clk edge when t=1.
// Latency one clock; no backpressure; async active-low clear_n forces q=0.
module t_ff_cell (
    input  logic clk,
    input  logic clear_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_ff_counter.sv
// Up/down counter built from T flip-flops with clear, load, terminal count and sticky wrap.
// Latency one clock from controls to q; no handshake. Optional scan chain: T_FF_COUNTER_SCAN_EN.
module t_ff_counter
    import t_ff_counter_pkg::*;
#(
    parameter int WIDTH = T_FF_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
`ifdef T_FF_COUNTER_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] step_t;
    logic [WIDTH-1:0] t;
    logic             wrap_clr;

    // The package helper covers the default width; other widths use the same rule inline.
    generate
        if (WIDTH == T_FF_WIDTH) begin : g_pkg_step
            assign step_t = t_vec(q, up);
        end else begin : g_gen_step
            always_comb begin
                step_t[0] = 1'b1;
                for (int i = 1; i < WIDTH; i++) begin
                    step_t[i] = step_t[i-1] & (up ? q[i-1] : ~q[i-1]);
                end
            end
        end
    endgenerate

    always_comb begin
        t        = '0;
        tc       = 1'b0;
        wrap_clr = 1'b0;
`ifdef T_FF_COUNTER_SCAN_EN
        if (scan_en) begin
            t = q ^ {q[WIDTH-2:0], scan_in};
        end else
`endif
        if (clr) begin
            t        = q;
            wrap_clr = 1'b1;
        end else if (load) begin
            t = q ^ load_val;
        end else if (en) begin
            t  = step_t;
            tc = up ? (&q) : ~(|q);
        end
    end

`ifdef T_FF_COUNTER_SCAN_EN
    assign scan_out = q[WIDTH-1];
`endif

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            t_ff_cell u_cell (
                .clk     (clk),
                .clear_n (clear_n),
                .t       (t[i]),
                .q       (q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wrap <= 1'b0;
        end else if (wrap_clr) begin
            wrap <= 1'b0;
        end else if (tc) begin
            wrap <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t_ff_counter.sv
// Scoreboarded bench for t_ff_counter (WIDTH=4): directed corner sequences, then random traffic.
module tb_t_ff_counter;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q;
    logic       tc, wrap;
    logic       scan_en = 1'b0, scan_in = 1'b0;
`ifdef T_FF_COUNTER_SCAN_EN
    logic       scan_out;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int  q_next;
        bit  wrap_next;
        bit  tc_now;
        bit  so_now;
        bit  chk_so;
        string tag;
    } exp_t;

    exp_t sb[$];

    // reference state
    int m_q = 0;
    bit m_wrap = 1'b0;

    t_ff_counter dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
`ifdef T_FF_COUNTER_SCAN_EN
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
`endif
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of controls at the falling edge and record the expected outcome.
    task automatic step(input bit c, input bit l, input int lv, input bit e, input bit u,
                        input bit se, input bit si, input string tag);
        exp_t x;
        @(negedge clk);
        clr = c; load = l; load_val = lv[3:0]; en = e; up = u;
        scan_en = se; scan_in = si;
        x.tag = tag;
        x.tc_now = 1'b0;
        x.so_now = m_q[3];
        x.chk_so = se;
        if (se) begin
            m_q = ((m_q * 2) + si) % 16;
        end else if (c) begin
            m_q = 0;
            m_wrap = 1'b0;
        end else if (l) begin
            m_q = lv % 16;
        end else if (e) begin
            if (u) begin
                x.tc_now = (m_q == 15);
                m_q = (m_q + 1) % 16;
            end else begin
                x.tc_now = (m_q == 0);
                m_q = (m_q + 15) % 16;
            end
            if (x.tc_now) m_wrap = 1'b1;
        end
        x.q_next = m_q;
        x.wrap_next = m_wrap;
        sb.push_back(x);
    endtask

    // Monitor: tc/scan_out sampled late in the low phase, q/wrap just after the rising edge.
    initial begin
        exp_t x;
        bit   tc_s, so_s;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                tc_s = tc;
`ifdef T_FF_COUNTER_SCAN_EN
                so_s = scan_out;
`else
                so_s = x.so_now;
`endif
                @(posedge clk);
                #1;
                check({x.tag, ".tc"}, int'(tc_s), int'(x.tc_now));
                if (x.chk_so) check({x.tag, ".scan_out"}, int'(so_s), int'(x.so_now));
                check({x.tag, ".q"}, int'(q), x.q_next);
                check({x.tag, ".wrap"}, int'(wrap), int'(x.wrap_next));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #1;
        check("reset.q", int'(q), 0);
        check("reset.wrap", int'(wrap), 0);
        @(negedge clk);
        clear_n = 1'b1;

        // async reset mid-count at 7
        step(0, 1, 7, 0, 1, 0, 0, "ld7");
        step(0, 0, 0, 1, 1, 0, 0, "inc8");
        step(0, 1, 7, 0, 1, 0, 0, "ld7b");
        @(negedge clk);
        clr = 0; load = 0; en = 1; up = 1;
        #1;
        clear_n = 1'b0;
        #1;
        check("async.q", int'(q), 0);
        check("async.wrap", int'(wrap), 0);
        en = 0;
        #1;
        clear_n = 1'b1;
        m_q = 0;
        m_wrap = 1'b0;
        step(0, 0, 0, 0, 1, 0, 0, "hold0");

        // count up 16 times through the F->0 wrap
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0, 0, "up16");

        // load A then count down three
        step(0, 1, 10, 0, 0, 0, 0, "ldA");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, "dn3");

        // load beats count at F; clr beats load
        step(1, 0, 0, 0, 0, 0, 0, "clr");
        step(0, 1, 15, 0, 0, 0, 0, "ldF");
        step(0, 1, 3, 1, 1, 0, 0, "ld_vs_en");
        step(1, 1, 9, 1, 1, 0, 0, "clr_vs_ld");

        // down wrap from 0, then clear
        step(0, 0, 0, 1, 0, 0, 0, "dnwrap");
        step(1, 0, 0, 1, 0, 0, 0, "clrwrap");

`ifdef T_FF_COUNTER_SCAN_EN
        step(0, 1, 5, 0, 0, 0, 0, "ld5");
        step(0, 0, 0, 1, 0, 0, 0, "dn4");
        step(0, 0, 0, 1, 0, 0, 0, "dn3b");
        step(0, 0, 0, 1, 0, 0, 0, "dn2");
        step(0, 0, 0, 1, 0, 0, 0, "dn1");
        step(0, 0, 0, 1, 0, 0, 0, "dn0");
        step(0, 0, 0, 1, 0, 0, 0, "dnF");
        step(1, 1, 6, 1, 1, 1, 1, "scan1");
        step(1, 0, 0, 1, 0, 1, 0, "scan0");
        step(0, 1, 2, 0, 1, 1, 1, "scan1b");
        step(0, 0, 0, 1, 1, 1, 1, "scan1c");
        step(0, 0, 0, 1, 1, 0, 0, "postscan");
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit se;
`ifdef T_FF_COUNTER_SCAN_EN
            se = ($urandom_range(0, 9) == 0);
`else
            se = 1'b0;
`endif
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)), se, bit'($urandom_range(0, 1)), "rand");
        end

        @(negedge clk);
        clr = 0; load = 0; en = 0; scan_en = 0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
